fetch_controller: RTL and testbench

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/fetch_controller.sv | 106 ++++++++++
 tb/tb_fetch_controller.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

   localparam int unsigned DEFAULT_MEM_BYTES = 64;
   localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0;

   // B-class opcode lives in bits [27:24] of the instruction word
   localparam logic [31:0] B_OPCODE_MASK  = 32'h0f00_0000;
   localparam logic [31:0] B_OPCODE_VALUE = 32'h0a00_0000;

   typedef enum logic [0:0] {FETCH, FAULT} state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        pred_taken;
   } entry_t;

   // Target of a B instruction: pc + 8 + sign-extended word offset
   function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                 input logic [31:0] instr);
      return pc + 32'd8 + {{6{instr[23]}}, instr[23:0], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry in-order queue of fetched instructions; slot 0 is the head.
module fetch_fifo
   import fetch_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       push_i,
   input  logic       pop_i,
   input  logic       flush_i,
   input  entry_t     push_entry_i,
   output logic [1:0] count_o,
   output entry_t     head_o
);

   entry_t     mem_q [2];
   entry_t     mem_d [2];
   logic [1:0] count_q;
   logic [1:0] count_d;

   // Next-state for slots and occupancy; push is only ever issued with space or a pop
   always_comb begin
      mem_d   = mem_q;
      count_d = count_q;
      if (flush_i) begin
         count_d = 2'd0;
      end else begin
         case ({push_i, pop_i})
            2'b10: begin
               mem_d[count_q[0]] = push_entry_i;
               count_d           = count_q + 2'd1;
            end
            2'b01: begin
               mem_d[0] = mem_q[1];
               count_d  = count_q - 2'd1;
            end
            2'b11: begin
               if (count_q == 2'd1) begin
                  mem_d[0] = push_entry_i;
               end else begin
                  mem_d[0] = mem_q[1];
                  mem_d[1] = push_entry_i;
               end
            end
            default: ;
         endcase
      end
   end

   // Queue state registers, cleared so the head reads zero in reset
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         count_q  <= 2'd0;
      end else begin
         mem_q[0] <= mem_d[0];
         mem_q[1] <= mem_d[1];
         count_q  <= count_d;
      end
   end

   assign count_o = count_q;
   assign head_o  = mem_q[0];

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: sequential fetch into a 2-entry queue with
// redirect, illegal-address fault and optional static backward-branch
// prediction enabled by defining FETCH_STATIC_PRED_EN.
// Note: nreset is active-high despite its name.
module fetch_controller
   import fetch_pkg::*;
#(
   parameter int unsigned MEM_BYTES = DEFAULT_MEM_BYTES,
   parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        nreset,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic        out_pred_taken,
   output logic        fault
);

   state_t      state_q;
   logic [31:0] pc_q;
   logic        fault_q;

   logic [1:0]  count;
   entry_t      head;
   entry_t      push_entry;
   logic        pop;
   logic        do_fetch;
   logic        pc_illegal;
   logic        redirect_legal;
   logic        pred;
   logic [31:0] next_pc;

   assign pc_illegal     = (pc_q >= MEM_BYTES) || (pc_q[1:0] != 2'b00);
   assign redirect_legal = (redirect_pc < MEM_BYTES) && (redirect_pc[1:0] == 2'b00);

   assign out_valid = (count != 2'd0);
   assign pop       = out_valid && out_ready;
   assign do_fetch  = (state_q == FETCH) && !pc_illegal && ((count < 2'd2) || pop)
                      && !redirect_valid;

`ifdef FETCH_STATIC_PRED_EN
   assign pred    = ((imem_data & B_OPCODE_MASK) == B_OPCODE_VALUE) && imem_data[23];
   assign next_pc = pred ? branch_target(pc_q, imem_data) : pc_q + 32'd4;
`else
   assign pred    = 1'b0;
   assign next_pc = pc_q + 32'd4;
`endif

   assign push_entry = '{pc: pc_q, instr: imem_data, pred_taken: pred};

   fetch_fifo u_fifo (
      .clk_i        (clk),
      .rst_i        (nreset),
      .push_i       (do_fetch),
      .pop_i        (pop),
      .flush_i      (redirect_valid),
      .push_entry_i (push_entry),
      .count_o      (count),
      .head_o       (head)
   );

   // Fetch FSM: redirect wins, otherwise advance pc or trap on an illegal address
   always_ff @(posedge clk or posedge nreset) begin
      if (nreset) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         fault_q <= 1'b0;
      end else if (redirect_valid) begin
         pc_q <= redirect_pc;
         if (redirect_legal) begin
            state_q <= FETCH;
            fault_q <= 1'b0;
         end else begin
            state_q <= FAULT;
            fault_q <= 1'b1;
         end
      end else begin
         case (state_q)
            FETCH: begin
               if (pc_illegal) begin
                  state_q <= FAULT;
                  fault_q <= 1'b1;
               end else if (do_fetch) begin
                  pc_q <= next_pc;
               end
            end
            FAULT: ;
            default: state_q <= FETCH;
         endcase
      end
   end

   // In FAULT pc is frozen, so the memory keeps seeing the last pc
   assign imem_addr      = pc_q;
   assign out_instr      = head.instr;
   assign out_pc         = head.pc;
   assign out_pred_taken = head.pred_taken;
   assign fault          = fault_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed self-checking bench for fetch_controller with a 16-word memory model.
module tb_fetch_controller;

   logic        clk = 1'b0;
   logic        nreset;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_pred_taken;
   logic        fault;

   int errors = 0;
   int checks = 0;

   logic [31:0] mem [16];

`ifdef FETCH_STATIC_PRED_EN
   localparam logic        EXP_PRED = 1'b1;
   localparam logic [31:0] EXP_NEXT = 32'd28;
`else
   localparam logic        EXP_PRED = 1'b0;
   localparam logic [31:0] EXP_NEXT = 32'd32;
`endif

   always #5 clk = ~clk;

   assign imem_data = ((imem_addr < 32'd64) && (imem_addr[1:0] == 2'b00)) ?
                      mem[imem_addr[5:2]] : 32'hdead_beef;

   fetch_controller dut (
      .clk            (clk),
      .nreset         (nreset),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .out_pred_taken (out_pred_taken),
      .fault          (fault)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic hold_reset();
      nreset         = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      step();
      step();
   endtask

   task automatic test_reset();
      out_ready = 1'b0;
      hold_reset();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", out_valid); end
      checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", out_pc); end
      checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h want 0", out_instr); end
      checks++; if (out_pred_taken !== 1'b0) begin errors++; $display("FAIL rst_pred: got %b want 0", out_pred_taken); end
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rst_fault: got %b want 0", fault); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_imem: got %h want 0", imem_addr); end
   endtask

   task automatic test_seq();
      out_ready = 1'b1;
      nreset    = 1'b0;
      step();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin errors++; $display("FAIL seq_pc0: got v=%b pc=%h want v=1 pc=0", out_valid, out_pc); end
      checks++; if (out_instr !== 32'he1a0_0000) begin errors++; $display("FAIL seq_instr0: got %h want e1a00000", out_instr); end
      step();
      checks++; if (out_pc !== 32'h4) begin errors++; $display("FAIL seq_pc4: got %h want 4", out_pc); end
      checks++; if (out_instr !== 32'he3a0_0008) begin errors++; $display("FAIL seq_instr4: got %h want e3a00008", out_instr); end
      step();
      checks++; if (out_pc !== 32'h8) begin errors++; $display("FAIL seq_pc8: got %h want 8", out_pc); end
   endtask

   task automatic test_stall();
      hold_reset();
      out_ready = 1'b0;
      nreset    = 1'b0;
      step();
      step();
      checks++; if (out_pc !== 32'h0 || imem_addr !== 32'h8) begin errors++; $display("FAIL stall_full: got pc=%h addr=%h want pc=0 addr=8", out_pc, imem_addr); end
      for (int i = 0; i < 5; i++) begin
         step();
         checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || imem_addr !== 32'h8) begin errors++; $display("FAIL stall_hold%0d: got v=%b pc=%h addr=%h want v=1 pc=0 addr=8", i, out_valid, out_pc, imem_addr); end
      end
      out_ready = 1'b1;
      step();
      checks++; if (out_pc !== 32'h4 || imem_addr !== 32'hc) begin errors++; $display("FAIL stall_resume4: got pc=%h addr=%h want pc=4 addr=c", out_pc, imem_addr); end
      step();
      checks++; if (out_pc !== 32'h8) begin errors++; $display("FAIL stall_resume8: got %h want 8", out_pc); end
   endtask

   task automatic test_redirect();
      hold_reset();
      out_ready = 1'b0;
      nreset    = 1'b0;
      step();
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h30;
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: got %b want 0", out_valid); end
      checks++; if (imem_addr !== 32'h30) begin errors++; $display("FAIL redir_addr: got %h want 30", imem_addr); end
      redirect_valid = 1'b0;
      out_ready      = 1'b1;
      step();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h30) begin errors++; $display("FAIL redir_pc: got v=%b pc=%h want v=1 pc=30", out_valid, out_pc); end
      checks++; if (out_instr !== 32'he1a0_000c) begin errors++; $display("FAIL redir_instr: got %h want e1a0000c", out_instr); end
   endtask

   task automatic test_fault();
      int n;
      hold_reset();
      out_ready = 1'b1;
      nreset    = 1'b0;
      n = 0;
      while (out_pc !== 32'd60 && n < 40) begin
         step();
         n++;
      end
      checks++; if (n != 16) begin errors++; $display("FAIL fault_reach60: got %0d cycles want 16", n); end
      out_ready = 1'b0;
      step();
      checks++; if (fault !== 1'b1 || imem_addr !== 32'd64) begin errors++; $display("FAIL fault_set: got f=%b addr=%h want f=1 addr=40", fault, imem_addr); end
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'd60) begin errors++; $display("FAIL fault_queued: got v=%b pc=%h want v=1 pc=3c", out_valid, out_pc); end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (out_pc !== 32'd60 || fault !== 1'b1 || imem_addr !== 32'd64) begin errors++; $display("FAIL fault_hold%0d: got pc=%h f=%b addr=%h want pc=3c f=1 addr=40", i, out_pc, fault, imem_addr); end
      end
      out_ready = 1'b1;
      step();
      checks++; if (out_valid !== 1'b0 || fault !== 1'b1) begin errors++; $display("FAIL fault_drain: got v=%b f=%b want v=0 f=1", out_valid, fault); end
      redirect_valid = 1'b1;
      redirect_pc    = 32'h4;
      step();
      checks++; if (fault !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL fault_clear: got f=%b v=%b want f=0 v=0", fault, out_valid); end
      redirect_valid = 1'b0;
      step();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h4) begin errors++; $display("FAIL fault_recover: got v=%b pc=%h want v=1 pc=4", out_valid, out_pc); end
   endtask

   task automatic test_misalign();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h6;
      step();
      checks++; if (fault !== 1'b1 || out_valid !== 1'b0 || imem_addr !== 32'h6) begin errors++; $display("FAIL mis_enter: got f=%b v=%b addr=%h want f=1 v=0 addr=6", fault, out_valid, imem_addr); end
      redirect_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++; if (fault !== 1'b1 || out_valid !== 1'b0 || imem_addr !== 32'h6) begin errors++; $display("FAIL mis_hold%0d: got f=%b v=%b addr=%h want f=1 v=0 addr=6", i, fault, out_valid, imem_addr); end
      end
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0;
      step();
      redirect_valid = 1'b0;
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL mis_clear: got %b want 0", fault); end
   endtask

   task automatic test_pred();
      int n;
      mem[7] = 32'hdaff_fffe;
      hold_reset();
      out_ready = 1'b1;
      nreset    = 1'b0;
      n = 0;
      while (out_pc !== 32'd28 && n < 40) begin
         step();
         n++;
      end
      checks++; if (n != 8) begin errors++; $display("FAIL pred_reach28: got %0d cycles want 8", n); end
      checks++; if (out_instr !== 32'hdaff_fffe) begin errors++; $display("FAIL pred_instr: got %h want dafffffe", out_instr); end
      checks++; if (out_pred_taken !== EXP_PRED) begin errors++; $display("FAIL pred_flag: got %b want %b", out_pred_taken, EXP_PRED); end
      checks++; if (imem_addr !== EXP_NEXT) begin errors++; $display("FAIL pred_addr: got %h want %h", imem_addr, EXP_NEXT); end
      step();
      checks++; if (out_pc !== EXP_NEXT || out_pred_taken !== EXP_PRED) begin errors++; $display("FAIL pred_next: got pc=%h p=%b want pc=%h p=%b", out_pc, out_pred_taken, EXP_NEXT, EXP_PRED); end
      mem[7] = 32'he1a0_0007;
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b1;
      step();
      step();
      nreset = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || imem_addr !== 32'h0 || fault !== 1'b0) begin errors++; $display("FAIL mid_rst: got v=%b pc=%h addr=%h f=%b want all 0", out_valid, out_pc, imem_addr, fault); end
      step();
      nreset = 1'b0;
      step();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin errors++; $display("FAIL mid_first: got v=%b pc=%h want v=1 pc=0", out_valid, out_pc); end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'he1a0_0000 | i;
      mem[1] = 32'he3a0_0008;
      nreset         = 1'b1;
      out_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      test_reset();
      test_seq();
      test_stall();
      test_redirect();
      test_fault();
      test_misalign();
      test_pred();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
